rsp_ahb_chmux: RTL and testbench
================================

# rsp_ahb_chmux

Parametrised AHB-Lite 1-to-N channel decoder/multiplexer for the RSP register and DMA fabric, the successor to the fixed five-channel DMA AHB mux. It decodes a per-channel address window, fans the address phase out to N_CH channel slaves, and tracks the data phase to return the selected slave's response. It includes a built-in default slave that answers unmapped accesses with ERROR. An optional watchdog converts a stalled channel into an ERROR response.

## Interface
- N_CH, 5: number of channel slaves, 1..16.
- AHB_DW, 32: data width.
- AHB_AW, 32: address width.
- CH_AW, 10: channel window address bits. The window is 2^CH_AW bytes.
- TIMEOUT_CYC, 256: wait-state limit before timeout abort. Used only with the watchdog macro. Must be at least 2.
- hclk  in  1  clock.
- hresetn  in  1  synchronous, active-low reset.
- hsel, htrans[1:0], haddr[AHB_AW-1:0], hburst[2:0], hsize[2:0], hwdata[AHB_DW-1:0], hwrite, hreadyin  in  master-side AHB-Lite inputs.
- hrdata  out  AHB_DW  read data to master.
- hresp  out  2  response to master.
- hready  out  1  ready to master.
- ch_hsel  out  N_CH  per-channel select.
- ch_htrans, ch_haddr, ch_hburst, ch_hsize, ch_hwdata, ch_hwrite, ch_hreadyin  out  N_CH×field  per-channel copies.
- ch_hrdata  in  N_CH×AHB_DW  channel read data.
- ch_hresp  in  N_CH×2  channel responses.
- ch_hready  in  N_CH  channel ready.
- ch_tmo  out  N_CH  sticky per-channel timeout flags.

## Operation
- **Decode:** idx = haddr[CH_AW +: clog2(N_CH)]. The access is mapped if hsel=1 and idx<N_CH and idx's ch_tmo=0; otherwise it goes to the default slave.
- **Address-phase fan-out (combinational):**
  - ch_hsel[i] = mapped & (idx==i).
  - ch_haddr[i] = haddr & (2^CH_AW−1).
  - Other fields are replicated to every channel.
  - ch_hreadyin[i] = hready.
- **Data-phase select register dsel:** N_CH+1 states, one per channel plus DEF. It loads the decoded target when hreadyin=1. It holds otherwise.
- **Channel selected in data phase:** hrdata, hresp and hready come from that channel.
- **DEF selected in data phase:**
  - hrdata=0.
  - If the address phase was IDLE/BUSY or hsel=0: zero-wait OKAY.
  - If the address phase was NONSEQ/SEQ: two-cycle ERROR.
- **Default-slave FSM:** OKAY → ERR1 → ERR2 → OKAY.
  - ERR1: hready=0, hresp=ERROR.
  - ERR2: hready=1, hresp=ERROR.
- A new address phase presented during ERR2 is decoded normally.

## Timing
- **Reset values:**
  - dsel=DEF, FSM=OKAY, ch_tmo=0.
  - hready=1, hresp=OKAY, hrdata=0.
  - ch_hsel follows its inputs combinationally; it is 0 when hsel=0.
- **Latency:** no added wait states on mapped accesses. The response path from channel to master is combinational.
- **Back-to-back accesses to different channels:** dsel switches on the same edge that completes the prior data phase.
- **Channel ERROR:** a channel's two-cycle ERROR is passed through unchanged.
- **Reset mid-transfer:** reset aborts the transfer with no response. Outputs take their reset values on the next edge.
- **Unmapped burst:** every beat gets a two-cycle ERROR.

## Configuration
- **With RSP_AHB_CHMUX_TIMEOUT_EN defined:**
  - A counter counts consecutive cycles in which the selected channel drives ch_hready=0.
  - When the count reaches TIMEOUT_CYC, dsel is forced to DEF in ERR1. The module then completes the standard two-cycle ERROR.
  - The offending channel's ch_tmo bit is set and stays set until reset. That channel decodes as unmapped from then on.
  - The counter clears on ch_hready=1 or on a dsel change.
- **Without the macro:** no counter is built, ch_tmo is tied to 0, and a stalled channel stalls the master indefinitely.

## Structure
- **Shared package rsp_ahb_pkg:**
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HRESP_OKAY/ERROR.
  - Default-slave FSM state enum.
  - Function clog2_min1, which returns 1 when N_CH=1.
- **Sub-module rsp_ahb_defslave:** the default-slave ERROR FSM plus the optional watchdog counter.
- **Top level:** decode, dsel register and response muxing.

## Test plan
- **Mapped write:** N_CH=5, CH_AW=10; write NONSEQ to haddr=0x0000_0C10 → ch_hsel=5'b01000 and ch_haddr[3]=0x010. Channel 3 inserts 2 wait states → hready low for 2 cycles, then OKAY.
- **Back-to-back reads:** ch0 read then ch4 read with zero waits → hrdata equals ch_hrdata[0], then ch_hrdata[4], on consecutive cycles.
- **Unmapped access:** haddr=0x0000_1400 (idx=5) NONSEQ → no ch_hsel. Response is hready=0/hresp=ERROR, then hready=1/hresp=ERROR. An IDLE to the same address → zero-wait OKAY.
- **Channel ERROR pass-through:** ch2 returns a two-cycle ERROR → identical hresp/hready seen at the master.
- **Watchdog (macro on, TIMEOUT_CYC=8):** ch1 holds hready low → ERROR pair starts at cycle 8 and ch_tmo[1]=1. A later access to ch1 → default ERROR with ch_hsel[1]=0.
- **Reset:** assert hresetn=0 during a ch0 wait state → next edge gives hready=1, hresp=OKAY, dsel=DEF and ch_tmo=0.

Source files
------------

// File: rtl/rsp_ahb_pkg.sv
// ----------------------------------------------------------------------------
// rsp_ahb_pkg
// Shared AHB-Lite encodings and helpers for the RSP register/DMA fabric.
//   - HTRANS_* / HRESP_* encodings
//   - ds_state_e : default-slave ERROR FSM states
//   - clog2_min1 : ceil(log2(n)), never less than 1 (so N_CH=1 still has an
//                  index field)
// ----------------------------------------------------------------------------
package rsp_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        DS_OKAY = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rsp_ahb_defslave.sv
// ----------------------------------------------------------------------------
// rsp_ahb_defslave
// Default slave for rsp_ahb_chmux: two-cycle ERROR FSM for unmapped active
// transfers, plus the optional stall watchdog (macro RSP_AHB_CHMUX_TIMEOUT_EN).
//
// Ports
//   i_hclk, i_hresetn : clock, synchronous active-low reset
//   i_hreadyin        : bus-level HREADY (address phase accepted when 1)
//   i_err_req         : current address phase is active and unmapped
//   i_stall           : selected channel is in data phase with ch_hready=0
//   i_dsel_chg        : data-phase select is about to change
//   i_dsel_ch         : channel index currently selected in data phase
//   o_hready, o_hresp : default-slave response (registered)
//   o_trip            : watchdog expired this cycle (forces dsel to DEF)
//   o_ch_tmo          : sticky per-channel timeout flags
// ----------------------------------------------------------------------------
module rsp_ahb_defslave
    import rsp_ahb_pkg::*;
#(
    parameter int N_CH        = 5,
    parameter int IDXW        = 3,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic            i_hclk,
    input  logic            i_hresetn,
    input  logic            i_hreadyin,
    input  logic            i_err_req,
    input  logic            i_stall,
    input  logic            i_dsel_chg,
    input  logic [IDXW-1:0] i_dsel_ch,
    output logic            o_hready,
    output logic [1:0]      o_hresp,
    output logic            o_trip,
    output logic [N_CH-1:0] o_ch_tmo
);

    ds_state_e  r_state;
    logic       r_hready;
    logic [1:0] r_hresp;
    logic       w_trip;

`ifdef RSP_AHB_CHMUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [N_CH-1:0]  r_tmo;

    // Trip on the last stalled cycle so ERR1 appears after exactly
    // TIMEOUT_CYC wait states.
    assign w_trip = i_stall && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_hclk) begin
        if (!i_hresetn) begin
            r_cnt <= '0;
            r_tmo <= '0;
        end else begin
            if (!i_stall || i_dsel_chg || w_trip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_trip) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (i_dsel_ch == IDXW'(i)) begin
                        r_tmo[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_ch_tmo = r_tmo;
`else
    logic w_unused;
    assign w_unused = ^{i_stall, i_dsel_chg, i_dsel_ch};
    assign w_trip   = 1'b0;
    assign o_ch_tmo = '0;
`endif

    assign o_trip = w_trip;

    // ERR2 accepts a new address phase like OKAY does, so a back-to-back
    // unmapped beat goes straight to ERR1 again.
    always_ff @(posedge i_hclk) begin
        if (!i_hresetn) begin
            r_state  <= DS_OKAY;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
        end else if (w_trip) begin
            r_state  <= DS_ERR1;
            r_hready <= 1'b0;
            r_hresp  <= HRESP_ERROR;
        end else begin
            case (r_state)
                DS_ERR1: begin
                    r_state  <= DS_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_ERROR;
                end
                default: begin
                    if (i_hreadyin && i_err_req) begin
                        r_state  <= DS_ERR1;
                        r_hready <= 1'b0;
                        r_hresp  <= HRESP_ERROR;
                    end else begin
                        r_state  <= DS_OKAY;
                        r_hready <= 1'b1;
                        r_hresp  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign o_hready = r_hready;
    assign o_hresp  = r_hresp;

endmodule

// File: rtl/rsp_ahb_chmux.sv
// ----------------------------------------------------------------------------
// rsp_ahb_chmux
// AHB-Lite 1-to-N_CH channel decoder/multiplexer. Channel index is
// haddr[CH_AW +: clog2(N_CH)]; each channel sees a 2^CH_AW byte window.
// Unmapped (or timed-out) accesses go to a built-in default slave that
// answers active transfers with a two-cycle ERROR.
// Optional watchdog: define RSP_AHB_CHMUX_TIMEOUT_EN.
//
// Ports
//   hclk, hresetn          : clock, synchronous active-low reset
//   hsel..hreadyin         : master-side AHB-Lite address/data inputs
//   hrdata, hresp, hready  : response to master
//   ch_hsel..ch_hreadyin   : per-channel address-phase fan-out
//   ch_hrdata/hresp/hready : per-channel responses
//   ch_tmo                 : sticky per-channel timeout flags
// ----------------------------------------------------------------------------
module rsp_ahb_chmux
    import rsp_ahb_pkg::*;
#(
    parameter int N_CH        = 5,
    parameter int AHB_DW      = 32,
    parameter int AHB_AW      = 32,
    parameter int CH_AW       = 10,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                             hclk,
    input  logic                             hresetn,
    input  logic                             hsel,
    input  logic [1:0]                       htrans,
    input  logic [AHB_AW-1:0]                haddr,
    input  logic [2:0]                       hburst,
    input  logic [2:0]                       hsize,
    input  logic [AHB_DW-1:0]                hwdata,
    input  logic                             hwrite,
    input  logic                             hreadyin,
    output logic [AHB_DW-1:0]                hrdata,
    output logic [1:0]                       hresp,
    output logic                             hready,
    output logic [N_CH-1:0]                  ch_hsel,
    output logic [N_CH-1:0][1:0]             ch_htrans,
    output logic [N_CH-1:0][AHB_AW-1:0]      ch_haddr,
    output logic [N_CH-1:0][2:0]             ch_hburst,
    output logic [N_CH-1:0][2:0]             ch_hsize,
    output logic [N_CH-1:0][AHB_DW-1:0]      ch_hwdata,
    output logic [N_CH-1:0]                  ch_hwrite,
    output logic [N_CH-1:0]                  ch_hreadyin,
    input  logic [N_CH-1:0][AHB_DW-1:0]      ch_hrdata,
    input  logic [N_CH-1:0][1:0]             ch_hresp,
    input  logic [N_CH-1:0]                  ch_hready,
    output logic [N_CH-1:0]                  ch_tmo
);

    localparam int IDXW = clog2_min1(N_CH);
    localparam logic [AHB_AW-1:0] ADDR_MASK = AHB_AW'((64'd1 << CH_AW) - 64'd1);

    logic [IDXW-1:0] w_idx;
    logic [N_CH-1:0] w_hit;
    logic            w_mapped;
    logic            w_err_req;
    logic            w_stall;
    logic            w_dsel_chg;
    logic            w_trip;
    logic            w_def_hready;
    logic [1:0]      w_def_hresp;

    // Data-phase select: r_dsel_def=1 means the default slave, otherwise
    // r_dsel_ch names the channel.
    logic            r_dsel_def;
    logic [IDXW-1:0] r_dsel_ch;

    assign w_idx = haddr[CH_AW +: IDXW];

    // Indices >= N_CH never hit, so they fall through to the default slave.
    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_hit[i] = (w_idx == IDXW'(i)) && !ch_tmo[i];
        end
    end

    assign w_mapped  = hsel && (|w_hit);
    assign w_err_req = hsel && !w_mapped &&
                       ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_hsel[i]     = w_hit[i] && hsel;
            ch_htrans[i]   = htrans;
            ch_haddr[i]    = haddr & ADDR_MASK;
            ch_hburst[i]   = hburst;
            ch_hsize[i]    = hsize;
            ch_hwdata[i]   = hwdata;
            ch_hwrite[i]   = hwrite;
            ch_hreadyin[i] = hready;
        end
    end

    assign w_stall    = !r_dsel_def && !ch_hready[r_dsel_ch];
    assign w_dsel_chg = hreadyin &&
                        (w_mapped ? (r_dsel_def || (w_idx != r_dsel_ch)) : !r_dsel_def);

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_dsel_def <= 1'b1;
            r_dsel_ch  <= '0;
        end else if (w_trip) begin
            r_dsel_def <= 1'b1;
        end else if (hreadyin) begin
            r_dsel_def <= !w_mapped;
            if (w_mapped) begin
                r_dsel_ch <= w_idx;
            end
        end
    end

    rsp_ahb_defslave #(
        .N_CH        (N_CH),
        .IDXW        (IDXW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_defslave (
        .i_hclk     (hclk),
        .i_hresetn  (hresetn),
        .i_hreadyin (hreadyin),
        .i_err_req  (w_err_req),
        .i_stall    (w_stall),
        .i_dsel_chg (w_dsel_chg),
        .i_dsel_ch  (r_dsel_ch),
        .o_hready   (w_def_hready),
        .o_hresp    (w_def_hresp),
        .o_trip     (w_trip),
        .o_ch_tmo   (ch_tmo)
    );

    always_comb begin
        hrdata = '0;
        hresp  = w_def_hresp;
        hready = w_def_hready;
        if (!r_dsel_def) begin
            hrdata = ch_hrdata[r_dsel_ch];
            hresp  = ch_hresp[r_dsel_ch];
            hready = ch_hready[r_dsel_ch];
        end
    end

endmodule

// File: tb/tb_rsp_ahb_chmux.sv
module tb_rsp_ahb_chmux;

    localparam int N_CH  = 5;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int CH_AW = 10;

    logic                     hclk = 1'b0;
    logic                     hresetn;
    logic                     hsel;
    logic [1:0]               htrans;
    logic [AW-1:0]            haddr;
    logic [2:0]               hburst;
    logic [2:0]               hsize;
    logic [DW-1:0]            hwdata;
    logic                     hwrite;
    logic                     hreadyin;
    logic [DW-1:0]            hrdata;
    logic [1:0]               hresp;
    logic                     hready;
    logic [N_CH-1:0]          ch_hsel;
    logic [N_CH-1:0][1:0]     ch_htrans;
    logic [N_CH-1:0][AW-1:0]  ch_haddr;
    logic [N_CH-1:0][2:0]     ch_hburst;
    logic [N_CH-1:0][2:0]     ch_hsize;
    logic [N_CH-1:0][DW-1:0]  ch_hwdata;
    logic [N_CH-1:0]          ch_hwrite;
    logic [N_CH-1:0]          ch_hreadyin;
    logic [N_CH-1:0][DW-1:0]  ch_hrdata;
    logic [N_CH-1:0][1:0]     ch_hresp;
    logic [N_CH-1:0]          ch_hready;
    logic [N_CH-1:0]          ch_tmo;

    int n_checks = 0;
    int n_errors = 0;

    // Single-slave bus: HREADY loops back as HREADYIN.
    assign hreadyin = hready;

    always #5 hclk = ~hclk;

    rsp_ahb_chmux #(
        .N_CH        (N_CH),
        .AHB_DW      (DW),
        .AHB_AW      (AW),
        .CH_AW       (CH_AW),
        .TIMEOUT_CYC (8)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hsel        (hsel),
        .htrans      (htrans),
        .haddr       (haddr),
        .hburst      (hburst),
        .hsize       (hsize),
        .hwdata      (hwdata),
        .hwrite      (hwrite),
        .hreadyin    (hreadyin),
        .hrdata      (hrdata),
        .hresp       (hresp),
        .hready      (hready),
        .ch_hsel     (ch_hsel),
        .ch_htrans   (ch_htrans),
        .ch_haddr    (ch_haddr),
        .ch_hburst   (ch_hburst),
        .ch_hsize    (ch_hsize),
        .ch_hwdata   (ch_hwdata),
        .ch_hwrite   (ch_hwrite),
        .ch_hreadyin (ch_hreadyin),
        .ch_hrdata   (ch_hrdata),
        .ch_hresp    (ch_hresp),
        .ch_hready   (ch_hready),
        .ch_tmo      (ch_tmo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle: drive point is 1 time unit after the rising edge.
    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    // Let combinational paths settle before sampling (mid-cycle).
    task automatic settle;
        #3;
    endtask

    task automatic addr_phase(input logic sel, input logic [1:0] tr,
                              input logic [AW-1:0] a, input logic wr);
        hsel   = sel;
        htrans = tr;
        haddr  = a;
        hwrite = wr;
    endtask

    task automatic idle;
        addr_phase(1'b0, 2'b00, '0, 1'b0);
    endtask

    initial begin
        hresetn = 1'b0;
        hburst  = 3'b000;
        hsize   = 3'b010;
        hwdata  = '0;
        addr_phase(1'b0, 2'b10, 32'h0000_0C10, 1'b1);
        for (int i = 0; i < N_CH; i++) begin
            ch_hrdata[i] = 32'hC0DE_0000 + 32'(i);
            ch_hresp[i]  = 2'b00;
        end
        // All channels stalled: a reset default select must not see them.
        ch_hready = '0;

        // ---------------- reset state ----------------
        tick; tick;
        settle;
        check("rst_hready", 64'(hready), 64'd1);
        check("rst_hresp",  64'(hresp),  64'd0);
        check("rst_hrdata", 64'(hrdata), 64'd0);
        check("rst_tmo",    64'(ch_tmo), 64'd0);
        check("rst_hsel0",  64'(ch_hsel), 64'd0);

        hresetn   = 1'b1;
        ch_hready = '1;
        idle;
        tick;

        // ---------------- mapped write to ch3 with 2 waits ----------------
        addr_phase(1'b1, 2'b10, 32'h0000_0C10, 1'b1);
        settle;
        check("wr_chsel",    64'(ch_hsel),        64'b01000);
        check("wr_chaddr3",  64'(ch_haddr[3]),    64'h010);
        check("wr_chtrans3", 64'(ch_htrans[3]),   64'd2);
        check("wr_chwrite3", 64'(ch_hwrite[3]),   64'd1);
        check("wr_rdyin3",   64'(ch_hreadyin[3]), 64'd1);
        tick;
        idle;
        hwdata       = 32'h1234_5678;
        ch_hready[3] = 1'b0;
        settle;
        check("wr_wait1",    64'(hready),       64'd0);
        check("wr_chwdata3", 64'(ch_hwdata[3]), 64'h1234_5678);
        check("wr_rdyin_lo", 64'(ch_hreadyin[3]), 64'd0);
        tick;
        settle;
        check("wr_wait2",    64'(hready),       64'd0);
        tick;
        ch_hready[3] = 1'b1;
        settle;
        check("wr_done", 64'({hready, hresp}), 64'b100);
        tick;
        ch_hready[3] = 1'b0;
        settle;
        check("wr_after_def", 64'({hready, hresp}), 64'b100);
        ch_hready[3] = 1'b1;

        // ---------------- back-to-back reads ch0 then ch4 ----------------
        addr_phase(1'b1, 2'b10, 32'h0000_0000, 1'b0);
        tick;
        addr_phase(1'b1, 2'b10, 32'h0000_1000, 1'b0);
        settle;
        check("b2b_rd0",    64'(hrdata),  64'hC0DE_0000);
        check("b2b_rdy0",   64'(hready),  64'd1);
        check("b2b_chsel4", 64'(ch_hsel), 64'b10000);
        tick;
        idle;
        settle;
        check("b2b_rd4", 64'(hrdata), 64'hC0DE_0004);
        tick;
        settle;
        check("b2b_def_rd", 64'(hrdata), 64'd0);

        // ---------------- unmapped NONSEQ, then IDLE to same address ------
        addr_phase(1'b1, 2'b10, 32'h0000_1400, 1'b0);
        settle;
        check("um_chsel", 64'(ch_hsel), 64'd0);
        tick;
        addr_phase(1'b1, 2'b00, 32'h0000_1400, 1'b0);
        settle;
        check("um_err1",    64'({hready, hresp}), 64'b001);
        check("um_hrdata",  64'(hrdata), 64'd0);
        tick;
        settle;
        check("um_err2",    64'({hready, hresp}), 64'b101);
        tick;
        settle;
        check("um_idle_ok", 64'({hready, hresp}), 64'b100);

        // ---------------- unmapped burst: each beat errors ----------------
        addr_phase(1'b1, 2'b10, 32'h0000_1400, 1'b0);
        tick;
        addr_phase(1'b1, 2'b11, 32'h0000_1404, 1'b0);
        settle;
        check("ub_b0_err1", 64'({hready, hresp}), 64'b001);
        tick;
        settle;
        check("ub_b0_err2", 64'({hready, hresp}), 64'b101);
        tick;
        idle;
        settle;
        check("ub_b1_err1", 64'({hready, hresp}), 64'b001);
        tick;
        settle;
        check("ub_b1_err2", 64'({hready, hresp}), 64'b101);
        tick;
        settle;
        check("ub_ok",      64'({hready, hresp}), 64'b100);

        // ---------------- ch2 ERROR pass-through ----------------
        addr_phase(1'b1, 2'b10, 32'h0000_0800, 1'b1);
        tick;
        idle;
        ch_hready[2] = 1'b0;
        ch_hresp[2]  = 2'b01;
        settle;
        check("ce_err1", 64'({hready, hresp}), 64'b001);
        tick;
        ch_hready[2] = 1'b1;
        settle;
        check("ce_err2", 64'({hready, hresp}), 64'b101);
        tick;
        ch_hresp[2] = 2'b00;
        settle;
        check("ce_ok", 64'({hready, hresp}), 64'b100);

        // ---------------- stalled ch1 ----------------
        addr_phase(1'b1, 2'b10, 32'h0000_0400, 1'b0);
        tick;
        idle;
        ch_hready[1] = 1'b0;
`ifdef RSP_AHB_CHMUX_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            settle;
            check("wd_stall", 64'({hready, hresp}), 64'b000);
            tick;
        end
        settle;
        check("wd_err1", 64'({hready, hresp}), 64'b001);
        check("wd_tmo",  64'(ch_tmo), 64'b00010);
        tick;
        addr_phase(1'b1, 2'b10, 32'h0000_0400, 1'b0);
        settle;
        check("wd_err2",    64'({hready, hresp}), 64'b101);
        check("wd_chsel1",  64'(ch_hsel), 64'd0);
        tick;
        idle;
        settle;
        check("wd_re_err1", 64'({hready, hresp}), 64'b001);
        tick;
        settle;
        check("wd_re_err2", 64'({hready, hresp}), 64'b101);
        tick;
        settle;
        check("wd_ok",      64'({hready, hresp}), 64'b100);
        ch_hready[1] = 1'b1;
`else
        for (int c = 0; c < 20; c++) begin
            settle;
            check("stall_hold", 64'({hready, hresp}), 64'b000);
            check("stall_tmo",  64'(ch_tmo), 64'd0);
            tick;
        end
        ch_hready[1] = 1'b1;
        settle;
        check("stall_done", 64'({hready, hresp}), 64'b100);
        tick;
`endif

        // ---------------- reset during ch0 wait state ----------------
        addr_phase(1'b1, 2'b10, 32'h0000_0000, 1'b0);
        tick;
        idle;
        ch_hready[0] = 1'b0;
        settle;
        check("rm_wait", 64'(hready), 64'd0);
        tick;
        hresetn = 1'b0;
        tick;
        settle;
        check("rm_rdy_resp", 64'({hready, hresp}), 64'b100);
        check("rm_hrdata",   64'(hrdata), 64'd0);
        check("rm_tmo",      64'(ch_tmo), 64'd0);
        hresetn = 1'b1;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
